mario_motion: RTL and testbench
===============================

# mario_motion

Produces Mario's screen position (`curr_h`, `curr_v`) and sprite selection (`sprite_selec`) for the sprite renderer. It reads the player buttons, runs walking and jumping physics once per video frame, and drives registered outputs. The outputs change only right after a frame tick, so the renderer never sees a position change mid-frame. It sits between the input/debounce logic and the Mario sprite-drawing stage of the VGA pipeline.

## Interface
Parameters:
- `H_START`, 32: horizontal position after reset.
- `H_MAX`, 608: rightmost `curr_h` (640 − 32); the leftmost is 0.
- `GROUND_V`, 416: `curr_v` when standing on the ground.
- `STEP_H`, 2: pixels moved horizontally per frame.
- `JUMP_STEP`, 4: pixels moved vertically per frame, both rising and falling.
- `JUMP_FRAMES`, 20: number of rising frames. Constraint: `JUMP_FRAMES*JUMP_STEP <= GROUND_V`.
- `WALK_ANIM`, 8: frames per walk-animation phase.

Ports:
- `clk` in 1: pixel clock, the only clock.
- `rst_n` in 1: asynchronous active-low reset.
- `frame_tick` in 1: one-cycle pulse per frame, at vblank start.
- `btn_left`, `btn_right`, `btn_jump` in 1 each: debounced, active-high, synchronous to `clk`.
- `curr_h` out 10: sprite left edge.
- `curr_v` out 10: sprite top edge.
- `sprite_selec` out 2: 00 = stand, 01 = move, 10 = jump; 11 is never driven.
- `airborne` out 1: high in the RISE and FALL states.

## Operation
- FSM states: GROUND, RISE, FALL. All updates below happen only on cycles where `frame_tick = 1`.
- Jump request:
  - `jump_pending` is set on any rising edge of `btn_jump`.
  - It is cleared on every `frame_tick`, whether or not the jump was used.
  - An edge and a tick in the same cycle count as a request for that tick.
- GROUND: if `jump_pending` is set, load `jcnt = JUMP_FRAMES` and go to RISE. `curr_v` does not change on that tick.
- RISE: `curr_v -= JUMP_STEP` and `jcnt -= 1`. When `jcnt` reaches 0 after the decrement, go to FALL.
- FALL:
  - If `curr_v + JUMP_STEP >= GROUND_V`: set `curr_v = GROUND_V` and go to GROUND.
  - Otherwise: `curr_v += JUMP_STEP`.
- Jump requests in RISE or FALL are ignored (no double jump).
- Horizontal movement applies in every state:
  - Right only: `curr_h = min(curr_h + STEP_H, H_MAX)`.
  - Left only: `curr_h = max(curr_h − STEP_H, 0)`, computed without 10-bit underflow.
  - Both or neither pressed: no movement.
- Sprite select, registered and updated on the tick:
  - Next state RISE or FALL: 10.
  - Next state GROUND and moving: walk phase. `acnt` counts moving ticks in GROUND (1..2·`WALK_ANIM`, wrapping). Output 01 for `acnt` in 1..`WALK_ANIM`, 00 for `WALK_ANIM`+1..2·`WALK_ANIM`.
  - Next state GROUND and not moving: 00, and `acnt` is cleared to 0.
  - `acnt` is also cleared when entering RISE.
- Arithmetic: positions are 10-bit unsigned, intermediate sums are 11-bit, and clamping is applied before truncation.

## Timing
- Reset (asynchronous, takes effect immediately on `rst_n` low): `curr_h = H_START`, `curr_v = GROUND_V`, `sprite_selec = 00`, `airborne = 0`, state GROUND, `jcnt = acnt = 0`, `jump_pending = 0`.
- Latency: every output updates on the clock edge that samples `frame_tick = 1`, and is visible the following cycle. Outputs stay stable for the whole frame.
- Reset mid-jump: returns to the ground position immediately. No partial state survives.
- Button changes between ticks have no effect, except that a `btn_jump` rising edge sets `jump_pending`.
- `frame_tick` held high for multiple cycles is illegal. If it happens, each high cycle counts as one tick.

## Test plan
- Reset: pulse `rst_n` low mid-simulation -> `curr_h = 32`, `curr_v = 416`, `sprite_selec = 00`, `airborne = 0` while low, before any clock edge.
- Walking: hold `btn_right` for 10 ticks -> `curr_h = 52`. `sprite_selec` = 01 after ticks 1–8 and 00 after ticks 9–10. Release, then 1 tick -> `curr_h = 52`, `sprite_selec = 00`.
- Jump arc: pulse `btn_jump` for 1 cycle, then 41 ticks.
  - After tick 1: `curr_v = 416`, `sprite_selec = 10`.
  - After tick 21: `curr_v = 336`.
  - After tick 41: `curr_v = 416`, `airborne = 0`, `sprite_selec = 00`.
- Clamp:
  - Hold right for 300 ticks -> `curr_h = 608` and stays there.
  - Then hold left for 400 ticks -> `curr_h = 0`, with no wrap to 1022.
  - Both buttons held -> `curr_h` unchanged.
- No double jump: press jump again during RISE at tick 5 -> the arc is identical to the single-jump case. A jump pulse placed in the same cycle as the landing tick is consumed: state stays GROUND and the next tick performs no jump.
- Reset mid-air: assert `rst_n` low at tick 10 of the jump -> `curr_v = 416` and `airborne = 0` immediately. After release, a new jump starts a full 20-frame rise.

Source files
------------

// File: rtl/mario_motion.sv
// ============================================================================
// Module   : mario_motion
// Purpose  : Per-frame walk/jump physics producing Mario's position and sprite.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mario_motion #(
    parameter int H_START     = 32,
    parameter int H_MAX       = 608,
    parameter int GROUND_V    = 416,
    parameter int STEP_H      = 2,
    parameter int JUMP_STEP   = 4,
    parameter int JUMP_FRAMES = 20,
    parameter int WALK_ANIM   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    output logic [9:0] curr_h,
    output logic [9:0] curr_v,
    output logic [1:0] sprite_selec,
    output logic       airborne
);

    localparam int              c_acnt_w      = $clog2(2 * WALK_ANIM + 1);
    localparam logic [10:0]     c_h_max       = 11'(H_MAX);
    localparam logic [10:0]     c_ground_v    = 11'(GROUND_V);
    localparam logic [10:0]     c_step_h      = 11'(STEP_H);
    localparam logic [10:0]     c_jump_step   = 11'(JUMP_STEP);
    localparam logic [9:0]      c_h_start     = 10'(H_START);
    localparam logic [9:0]      c_jump_frames = 10'(JUMP_FRAMES);
    localparam logic [c_acnt_w-1:0] c_walk_anim   = c_acnt_w'(WALK_ANIM);
    localparam logic [c_acnt_w-1:0] c_walk_period = c_acnt_w'(2 * WALK_ANIM);
    localparam logic [c_acnt_w-1:0] c_acnt_one    = c_acnt_w'(1);

    typedef enum logic [1:0] {
        ST_GROUND = 2'd0,
        ST_RISE   = 2'd1,
        ST_FALL   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [9:0]            r_h;
    logic [9:0]            r_v;
    logic [1:0]            r_sprite;
    logic [9:0]            r_jcnt;
    logic [c_acnt_w-1:0]   r_acnt;
    logic                  r_jump_pending;
    logic                  r_jump_d;

    logic                  w_jump_edge;
    logic                  w_jump_req;
    logic                  w_move_right;
    logic                  w_move_left;
    logic [10:0]           w_h_wide;
    logic [10:0]           w_h_sum;
    logic [10:0]           w_v_sum;
    logic [9:0]            w_h_next;
    logic [9:0]            w_v_next;
    logic [9:0]            w_jcnt_dec;
    logic [9:0]            w_jcnt_next;
    logic [c_acnt_w-1:0]   w_acnt_inc;
    logic [c_acnt_w-1:0]   w_acnt_next;
    logic [1:0]            w_sprite_next;

    // An edge coinciding with the tick is honoured on that same tick.
    assign w_jump_edge  = btn_jump & ~r_jump_d;
    assign w_jump_req   = r_jump_pending | w_jump_edge;
    assign w_move_right = btn_right & ~btn_left;
    assign w_move_left  = btn_left & ~btn_right;
    assign w_h_wide     = {1'b0, r_h};
    assign w_h_sum      = w_h_wide + c_step_h;
    assign w_v_sum      = {1'b0, r_v} + c_jump_step;
    assign w_jcnt_dec   = r_jcnt - 10'd1;
    assign w_acnt_inc   = (r_acnt >= c_walk_period) ? c_acnt_one : r_acnt + c_acnt_one;

    always_comb begin
        w_h_next = r_h;
        if (w_move_right) begin
            w_h_next = (w_h_sum > c_h_max) ? c_h_max[9:0] : w_h_sum[9:0];
        end else if (w_move_left) begin
            w_h_next = (w_h_wide < c_step_h) ? 10'd0 : (r_h - c_step_h[9:0]);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_v_next     = r_v;
        w_jcnt_next  = r_jcnt;
        case (r_state)
            ST_GROUND: begin
                if (w_jump_req) begin
                    w_state_next = ST_RISE;
                    w_jcnt_next  = c_jump_frames;
                end
            end
            ST_RISE: begin
                w_v_next    = r_v - c_jump_step[9:0];
                w_jcnt_next = w_jcnt_dec;
                if (w_jcnt_dec == 10'd0) begin
                    w_state_next = ST_FALL;
                end
            end
            ST_FALL: begin
                if (w_v_sum >= c_ground_v) begin
                    w_v_next     = c_ground_v[9:0];
                    w_state_next = ST_GROUND;
                end else begin
                    w_v_next = w_v_sum[9:0];
                end
            end
            default: begin
                w_state_next = ST_GROUND;
            end
        endcase
    end

    // Sprite follows the state the tick lands in, not the one it leaves.
    always_comb begin
        w_acnt_next   = r_acnt;
        w_sprite_next = 2'b00;
        if (w_state_next != ST_GROUND) begin
            w_sprite_next = 2'b10;
            if (r_state == ST_GROUND) begin
                w_acnt_next = '0;
            end
        end else if (w_move_right || w_move_left) begin
            w_acnt_next   = w_acnt_inc;
            w_sprite_next = (w_acnt_inc <= c_walk_anim) ? 2'b01 : 2'b00;
        end else begin
            w_acnt_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_GROUND;
        end else if (frame_tick) begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h            <= c_h_start;
            r_v            <= c_ground_v[9:0];
            r_sprite       <= 2'b00;
            r_jcnt         <= 10'd0;
            r_acnt         <= '0;
            r_jump_pending <= 1'b0;
            r_jump_d       <= 1'b0;
        end else begin
            r_jump_d <= btn_jump;
            if (frame_tick) begin
                r_h            <= w_h_next;
                r_v            <= w_v_next;
                r_sprite       <= w_sprite_next;
                r_jcnt         <= w_jcnt_next;
                r_acnt         <= w_acnt_next;
                r_jump_pending <= 1'b0;
            end else if (w_jump_edge) begin
                r_jump_pending <= 1'b1;
            end
        end
    end

    assign curr_h       = r_h;
    assign curr_v       = r_v;
    assign sprite_selec = r_sprite;
    assign airborne     = (r_state != ST_GROUND);

endmodule

`default_nettype wire

// File: tb/tb_mario_motion.sv
// ============================================================================
// Module   : tb_mario_motion
// Purpose  : Self-checking bench for mario_motion with a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mario_motion;

    localparam int H_START     = 32;
    localparam int H_MAX       = 608;
    localparam int GROUND_V    = 416;
    localparam int STEP_H      = 2;
    localparam int JUMP_STEP   = 4;
    localparam int JUMP_FRAMES = 20;
    localparam int WALK_ANIM   = 8;

    logic       clk;
    logic       rst_n;
    logic       frame_tick;
    logic       btn_left;
    logic       btn_right;
    logic       btn_jump;
    logic [9:0] curr_h;
    logic [9:0] curr_v;
    logic [1:0] sprite_selec;
    logic       airborne;

    int checks   = 0;
    int failures = 0;

    // Frame-level reference: the jump is tracked as "ticks since launch".
    int m_h, m_v, m_spr, m_t, m_walk;
    bit m_air, m_pending, m_jprev;

    typedef struct {
        bit l;
        bit r;
        int exp_h;
        int exp_spr;
    } walk_vec_t;

    walk_vec_t wv[11];

    mario_motion #(
        .H_START    (H_START),
        .H_MAX      (H_MAX),
        .GROUND_V   (GROUND_V),
        .STEP_H     (STEP_H),
        .JUMP_STEP  (JUMP_STEP),
        .JUMP_FRAMES(JUMP_FRAMES),
        .WALK_ANIM  (WALK_ANIM)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_tick  (frame_tick),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .btn_jump    (btn_jump),
        .curr_h      (curr_h),
        .curr_v      (curr_v),
        .sprite_selec(sprite_selec),
        .airborne    (airborne)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d @%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_h = H_START; m_v = GROUND_V; m_spr = 0; m_t = 0; m_walk = 0;
        m_air = 0; m_pending = 0; m_jprev = 0;
    endtask

    task automatic model_tick(input bit l, input bit r, input bit req);
        int dir;
        dir = (r && !l) ? 1 : ((l && !r) ? -1 : 0);
        m_h = m_h + dir * STEP_H;
        if (m_h > H_MAX) m_h = H_MAX;
        if (m_h < 0) m_h = 0;
        if (!m_air) begin
            if (req) begin
                m_air = 1; m_t = 0; m_walk = 0;
            end
        end else begin
            m_t++;
            if (m_t <= JUMP_FRAMES) begin
                m_v = GROUND_V - JUMP_STEP * m_t;
            end else begin
                m_v = GROUND_V - JUMP_STEP * JUMP_FRAMES + JUMP_STEP * (m_t - JUMP_FRAMES);
                if (m_v >= GROUND_V) begin
                    m_v = GROUND_V; m_air = 0;
                end
            end
        end
        if (m_air) begin
            m_spr = 2;
        end else if (dir != 0) begin
            m_walk++;
            m_spr = (((m_walk - 1) % (2 * WALK_ANIM)) < WALK_ANIM) ? 1 : 0;
        end else begin
            m_walk = 0; m_spr = 0;
        end
    endtask

    task automatic model_clock(input bit t, input bit l, input bit r, input bit j);
        bit jedge;
        jedge = j && !m_jprev;
        if (t) begin
            model_tick(l, r, m_pending || jedge);
            m_pending = 0;
        end else if (jedge) begin
            m_pending = 1;
        end
        m_jprev = j;
    endtask

    task automatic step(input bit t, input bit l, input bit r, input bit j);
        @(negedge clk);
        frame_tick = t; btn_left = l; btn_right = r; btn_jump = j;
        @(posedge clk);
        model_clock(t, l, r, j);
        #1;
        check("model_h", int'(curr_h), m_h);
        check("model_v", int'(curr_v), m_v);
        check("model_sprite", int'(sprite_selec), m_spr);
        check("model_airborne", int'(airborne), int'(m_air));
    endtask

    task automatic tick(input bit l, input bit r);
        step(1'b1, l, r, 1'b0);
        step(1'b0, l, r, 1'b0);
    endtask

    task automatic jump_pulse();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        wv[0]  = '{1'b0, 1'b1, 34, 1};
        wv[1]  = '{1'b0, 1'b1, 36, 1};
        wv[2]  = '{1'b0, 1'b1, 38, 1};
        wv[3]  = '{1'b0, 1'b1, 40, 1};
        wv[4]  = '{1'b0, 1'b1, 42, 1};
        wv[5]  = '{1'b0, 1'b1, 44, 1};
        wv[6]  = '{1'b0, 1'b1, 46, 1};
        wv[7]  = '{1'b0, 1'b1, 48, 1};
        wv[8]  = '{1'b0, 1'b1, 50, 0};
        wv[9]  = '{1'b0, 1'b1, 52, 0};
        wv[10] = '{1'b0, 1'b0, 52, 0};

        rst_n = 1'b0; frame_tick = 1'b0;
        btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_h", int'(curr_h), 32);
        check("reset_v", int'(curr_v), 416);
        check("reset_sprite", int'(sprite_selec), 0);
        check("reset_airborne", int'(airborne), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Walking table
        for (int i = 0; i < 11; i++) begin
            tick(wv[i].l, wv[i].r);
            check("walk_h", int'(curr_h), wv[i].exp_h);
            check("walk_sprite", int'(sprite_selec), wv[i].exp_spr);
        end

        // Single jump arc
        jump_pulse();
        for (int k = 1; k <= 41; k++) begin
            tick(1'b0, 1'b0);
            if (k == 1) begin
                check("arc_t1_v", int'(curr_v), 416);
                check("arc_t1_sprite", int'(sprite_selec), 2);
            end
            if (k == 21) check("arc_t21_v", int'(curr_v), 336);
            if (k == 41) begin
                check("arc_t41_v", int'(curr_v), 416);
                check("arc_t41_airborne", int'(airborne), 0);
                check("arc_t41_sprite", int'(sprite_selec), 0);
            end
        end

        // Second press during rise, then a press on the landing tick
        jump_pulse();
        for (int k = 1; k <= 40; k++) begin
            tick(1'b0, 1'b0);
            if (k == 5) begin
                check("dj_t5_v", int'(curr_v), 400);
                jump_pulse();
            end
            if (k == 21) check("dj_t21_v", int'(curr_v), 336);
        end
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("dj_land_v", int'(curr_v), 416);
        check("dj_land_airborne", int'(airborne), 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0);
        check("land_press_consumed_air", int'(airborne), 0);
        check("land_press_consumed_v", int'(curr_v), 416);
        check("land_press_consumed_sprite", int'(sprite_selec), 0);

        // Horizontal clamps
        repeat (300) tick(1'b0, 1'b1);
        check("clamp_right", int'(curr_h), 608);
        repeat (400) tick(1'b1, 1'b0);
        check("clamp_left", int'(curr_h), 0);
        tick(1'b1, 1'b0);
        check("clamp_left_hold", int'(curr_h), 0);
        repeat (5) tick(1'b0, 1'b1);
        repeat (3) tick(1'b1, 1'b1);
        check("both_buttons", int'(curr_h), 10);

        // Reset mid-air
        jump_pulse();
        repeat (10) tick(1'b0, 1'b0);
        check("pre_reset_airborne", int'(airborne), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midair_reset_v", int'(curr_v), 416);
        check("midair_reset_airborne", int'(airborne), 0);
        check("midair_reset_h", int'(curr_h), 32);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        jump_pulse();
        for (int k = 1; k <= 22; k++) begin
            tick(1'b0, 1'b0);
            if (k == 21) begin
                check("rejump_t21_v", int'(curr_v), 336);
                check("rejump_t21_air", int'(airborne), 1);
            end
            if (k == 22) check("rejump_t22_v", int'(curr_v), 340);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 2) == 0), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
